// File: rtl/inst_rom_resp.sv
// Instruction-memory responder for the fetch interface: fixed-latency, stall-aware
// read pipeline over a preloadable word array, with misalign/range fault flagging.
module inst_rom_resp #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned XLEN        = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [63:0]     inst_addr,
  input  logic            inst_ena,
  input  logic            stall,
  input  logic            load_we,
  input  logic [63:0]     load_addr,
  input  logic [31:0]     load_data,
  output logic [XLEN-1:0] inst,
  output logic            inst_valid,
  output logic            inst_fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned SW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] rd_idx_c;
  logic [AW-1:0] wr_idx_c;
  logic          misalign_c;
  logic          rd_oor_c;
  logic          wr_oor_c;
  logic          fault_c;
  logic          accept_c;
  logic [31:0]   rd_word_c;
  logic          unused_c;

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] flt_q, flt_d;
  logic [31:0]        data_q [LATENCY];
  logic [31:0]        data_d [LATENCY];

  assign rd_idx_c   = inst_addr[2+AW-1:2];
  assign wr_idx_c   = load_addr[2+AW-1:2];
  assign misalign_c = |inst_addr[1:0];
  assign rd_oor_c   = |inst_addr[63:2+AW];
  assign wr_oor_c   = |load_addr[63:2+AW];
  assign fault_c    = misalign_c | rd_oor_c;
  assign accept_c   = inst_ena & ~stall;
  assign rd_word_c  = mem[rd_idx_c];
  assign unused_c   = ^load_addr[1:0];

  // Preload port: independent of stall, no reset on contents, out-of-range writes dropped.
  always_ff @(posedge clk) begin
    if (load_we && !wr_oor_c) begin
      mem[wr_idx_c] <= load_data;
    end
  end

  // Next-state for the response pipeline; stall freezes every stage.
  always_comb begin
    vld_d  = vld_q;
    flt_d  = flt_q;
    data_d = data_q;
    if (!stall) begin
      vld_d = LATENCY'({vld_q, accept_c});
      flt_d = LATENCY'({flt_q, accept_c & fault_c});
      if (accept_c) begin
        data_d[0] = fault_c ? NOP_WORD : rd_word_c;
      end
      // Data only moves with a valid entry so bubbles leave the output word unchanged.
      for (int unsigned i = 1; i < LATENCY; i++) begin
        if (vld_q[SW'(i - 1)]) begin
          data_d[SW'(i)] = data_q[SW'(i - 1)];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= '0;
      flt_q  <= '0;
      data_q <= '{default: '0};
    end else begin
      vld_q  <= vld_d;
      flt_q  <= flt_d;
      data_q <= data_d;
    end
  end

  assign inst       = XLEN'(data_q[LATENCY-1]);
  assign inst_valid = vld_q[LATENCY-1];
  assign inst_fault = flt_q[LATENCY-1];

endmodule

// File: tb/tb_inst_rom_resp.sv
// Directed bench for inst_rom_resp: vector table on a LATENCY=2 instance, plus
// reset and latency-sweep sequences across LATENCY=1/2/4 instances sharing stimulus.
module tb_inst_rom_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] inst_addr = '0;
  logic        inst_ena = 1'b0;
  logic        stall = 1'b0;
  logic        load_we = 1'b0;
  logic [63:0] load_addr = '0;
  logic [31:0] load_data = '0;

  logic [63:0] inst1, inst2, inst4;
  logic        v1, v2, v4;
  logic        f1, f2, f4;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inst_rom_resp #(.DEPTH_WORDS(4096), .LATENCY(1), .XLEN(64)) u_l1 (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_ena(inst_ena), .stall(stall),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .inst(inst1), .inst_valid(v1), .inst_fault(f1));

  inst_rom_resp #(.DEPTH_WORDS(4096), .LATENCY(2), .XLEN(64)) u_l2 (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_ena(inst_ena), .stall(stall),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .inst(inst2), .inst_valid(v2), .inst_fault(f2));

  inst_rom_resp #(.DEPTH_WORDS(4096), .LATENCY(4), .XLEN(64)) u_l4 (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_ena(inst_ena), .stall(stall),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .inst(inst4), .inst_valid(v4), .inst_fault(f4));

  typedef struct {
    logic        ena;
    logic [63:0] addr;
    logic        stl;
    logic        we;
    logic [63:0] la;
    logic [31:0] ld;
    logic        ev;
    logic        ef;
    logic [31:0] ei;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic ena, input logic [63:0] addr, input logic stl,
                     input logic we, input logic [63:0] la, input logic [31:0] ld,
                     input logic ev, input logic ef, input logic [31:0] ei);
    vec_t v;
    v.ena = ena; v.addr = addr; v.stl = stl; v.we = we; v.la = la; v.ld = ld;
    v.ev = ev; v.ef = ef; v.ei = ei;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] exp_word(input int idx);
    if (idx == 2) return 32'hDEAD_BEEF;
    return 32'h1000_0000 + 32'(idx);
  endfunction

  function automatic bit sweep_ena(input int j);
    return (j >= 0) && (j < 10) && (j % 2 == 0);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    // Rows: {ena, addr, stall, we, load_addr, load_data} -> {valid, fault, inst} seen after the edge.
    for (int i = 0; i < 8; i++)
      add(1'b0, '0, 1'b0, 1'b1, 64'(4 * i), 32'h1000_0000 + 32'(i), 1'b0, 1'b0, 32'h0);
    add(1'b1, 64'h0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 32'h0);
    for (int i = 1; i < 8; i++)
      add(1'b1, 64'(4 * i), 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h1000_0000 + 32'(i - 1));
    add(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h1000_0007);
    add(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 32'h1000_0007);
    add(1'b1, 64'h2,    1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 32'h1000_0007);
    add(1'b1, 64'h4000, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h0000_0013);
    add(1'b1, 64'h4,    1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h0000_0013);
    add(1'b0, '0,       1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h1000_0001);
    add(1'b0, '0,       1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 32'h1000_0001);
    add(1'b1, 64'h8, 1'b0, 1'b1, 64'h8, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h1000_0001);
    add(1'b1, 64'h8, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h1000_0002);
    add(1'b0, '0,    1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    add(1'b0, '0,    1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    add(1'b1, 64'h0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    add(1'b1, 64'h4, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h1000_0000);
    add(1'b1, 64'hC, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 32'h1000_0000);
    add(1'b1, 64'hC, 1'b1, 1'b1, 64'h30, 32'hCAFE_0012, 1'b1, 1'b0, 32'h1000_0000);
    add(1'b1, 64'hC, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 32'h1000_0000);
    add(1'b1, 64'hC, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h1000_0001);
    add(1'b0, '0,    1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h1000_0003);
    add(1'b0, '0,    1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 32'h1000_0003);
    add(1'b1, 64'h30, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 32'h1000_0003);
    add(1'b0, '0,     1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'hCAFE_0012);
    add(1'b0, '0,     1'b0, 1'b1, 64'h4000, 32'h0BAD_0BAD, 1'b0, 1'b0, 32'hCAFE_0012);
    add(1'b1, 64'h0,  1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 32'hCAFE_0012);
    add(1'b0, '0,     1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h1000_0000);
    add(1'b0, '0,     1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 32'h1000_0000);

    // Initial reset, asserted asynchronously.
    #1 rst = 1'b0;
    #1;
    chk("reset_async valid", 64'(v2), 64'h0);
    chk("reset_async inst", inst2, 64'h0);
    step();
    step();
    chk("reset valid", 64'(v2), 64'h0);
    chk("reset fault", 64'(f2), 64'h0);
    chk("reset inst", inst2, 64'h0);
    chk("reset valid l1", 64'(v1), 64'h0);
    chk("reset valid l4", 64'(v4), 64'h0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      inst_ena  = vecs[i].ena;
      inst_addr = vecs[i].addr;
      stall     = vecs[i].stl;
      load_we   = vecs[i].we;
      load_addr = vecs[i].la;
      load_data = vecs[i].ld;
      step();
      chk($sformatf("row%0d valid", i), 64'(v2), 64'(vecs[i].ev));
      chk($sformatf("row%0d fault", i), 64'(f2), 64'(vecs[i].ef));
      chk($sformatf("row%0d inst", i), inst2, 64'(vecs[i].ei));
    end
    stall = 1'b0;
    load_we = 1'b0;

    // Mid-stream reset with two responses in flight.
    inst_ena = 1'b1; inst_addr = 64'h4;
    step();
    inst_addr = 64'h8;
    step();
    chk("pre_rst valid", 64'(v2), 64'h1);
    chk("pre_rst inst", inst2, 64'h1000_0001);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst valid", 64'(v2), 64'h0);
    chk("mid_rst fault", 64'(f2), 64'h0);
    chk("mid_rst inst", inst2, 64'h0);
    step();
    chk("hold_rst valid", 64'(v2), 64'h0);
    rst = 1'b1;
    inst_addr = 64'h10;
    step();
    inst_ena = 1'b0;
    chk("post_rst stale valid", 64'(v2), 64'h0);
    chk("post_rst stale inst", inst2, 64'h0);
    step();
    chk("post_rst valid", 64'(v2), 64'h1);
    chk("post_rst inst", inst2, 64'h1000_0004);
    step();
    chk("post_rst drain", 64'(v2), 64'h0);
    for (int i = 0; i < 4; i++) step();

    // Alternating request pattern; each instance must echo it delayed by its latency.
    for (int k = 0; k < 16; k++) begin
      inst_ena  = sweep_ena(k);
      inst_addr = 64'(4 * (k % 8));
      step();
      chk($sformatf("sweep%0d l1 valid", k), 64'(v1), 64'(sweep_ena(k)));
      chk($sformatf("sweep%0d l2 valid", k), 64'(v2), 64'(sweep_ena(k - 1)));
      chk($sformatf("sweep%0d l4 valid", k), 64'(v4), 64'(sweep_ena(k - 3)));
      if (sweep_ena(k))
        chk($sformatf("sweep%0d l1 inst", k), inst1, 64'(exp_word(k % 8)));
      if (sweep_ena(k - 3))
        chk($sformatf("sweep%0d l4 inst", k), inst4, 64'(exp_word((k - 3) % 8)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/inst_rom_resp.md
# inst_rom_resp

Instruction-memory responder that sits opposite `if_stage` on the fetch interface. It accepts the fetch stage's `inst_addr` / `inst_ena` request stream and returns the addressed instruction word after a fixed, parameterised pipeline latency. It honours the pipeline `stall` by freezing in-flight responses, and flags misaligned or out-of-range fetches. A side write port preloads program images for simulation and boot.

## Interface
Parameters:
- `DEPTH_WORDS`, 4096: number of 32-bit instruction words stored; power of two, 16..65536.
- `LATENCY`, 2: cycles from request acceptance to response valid; legal range 1..4.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-low (asserted at 0).
- `inst_addr`  in  64  byte address of the fetch request.
- `inst_ena`  in  1  fetch request valid.
- `stall`  in  1  pipeline stall; freezes the response pipeline and blocks acceptance.
- `load_we`  in  1  preload write strobe.
- `load_addr`  in  64  preload byte address; word aligned; bits [1:0] ignored.
- `load_data`  in  32  preload instruction word.
- `inst`  out  `XLEN  response; instruction in [31:0], upper bits zero.
- `inst_valid`  out  1  `inst` / `inst_fault` carry a response this cycle.
- `inst_fault`  out  1  the response is for a faulting fetch.

## Operation
- Word index: `idx = inst_addr[2+log2(DEPTH_WORDS)-1 : 2]`.
- Acceptance: a request is accepted on a posedge where `rst`=1, `inst_ena`=1 and `stall`=0. No request is accepted while `stall`=1.
- Fault on acceptance:
  - misaligned when `inst_addr[1:0]` != 0;
  - out of range when `inst_addr[63:2]` >= `DEPTH_WORDS`.
  - A faulting response returns `inst` = 0x0000_0013 (NOP) zero-extended, with `inst_fault`=1. Memory is not read.
- Pipeline: `LATENCY` stages, each holding {valid, data-or-index, fault}.
  - Stage 0 captures the accepted request (memory read at capture) or a bubble.
  - Stages advance by one each non-stalled cycle.
  - The last stage drives the outputs.
- Stall: with `stall`=1 every stage holds. Outputs, including `inst_valid`, stay constant for the whole stall.
- Bubbles: a non-stalled cycle with `inst_ena`=0 inserts valid=0. The corresponding output cycle has `inst_valid`=0, `inst_fault`=0 and `inst` holding its last value.
- Preload:
  - `load_we`=1 writes `load_data` to word `load_addr[...:2]` at posedge, regardless of `stall`.
  - An out-of-range `load_addr` is dropped silently.
- Read/write collision: a same-cycle acceptance and preload to the same index is read-first; the response carries the old word.
- Memory contents are not affected by reset. Contents are X until written.

## Timing
- Reset values (immediately on `rst`=0, asynchronous): `inst`=0, `inst_valid`=0, `inst_fault`=0, and all stage valids=0.
- Reset mid-operation discards all in-flight responses. The first post-reset request is accepted on the first posedge with `rst`=1.
- Latency: a request accepted at posedge N produces `inst_valid`=1 during the cycle after posedge N+`LATENCY`-1. With `LATENCY`=1, the response is visible in the cycle following acceptance.
- Any stalled cycles between acceptance and output add one cycle each to the latency.
- Throughput: one request per non-stalled cycle. Responses arrive in request order, one-for-one; none is dropped or duplicated.
- `stall` asserted and deasserted on the same cycle as a new request: the request is not accepted. The requester must hold `inst_addr` / `inst_ena` until a non-stalled edge.
- Simultaneous `load_we` and `stall`: the write completes and the pipeline holds.

## Test plan
- Preload words 0..7 with 0x1000_0000+i. Then request addresses 0x0,0x4,...,0x1C back-to-back with `LATENCY`=2. Required: 8 consecutive valid responses 0x1000_0000..0x1000_0007, first one 2 cycles after the first acceptance, `inst_fault`=0.
- Request 0x2 (misaligned), then 0x4000 with `DEPTH_WORDS`=4096 (index 4096, out of range). Required: two responses with `inst`=0x13 and `inst_fault`=1. A following request to 0x4 returns 0x1000_0001 with fault=0.
- Stream requests and assert `stall` for 3 cycles while 2 responses are in flight. Required: outputs frozen for 3 cycles; the same two responses then emerge in order; the total latency of each grows by 3.
- Same posedge: request 0x8 and `load_we` to 0x8 with 0xDEAD_BEEF. Required: response 0x1000_0002. A re-request of 0x8 then returns 0xDEAD_BEEF.
- Pull `rst` low mid-stream with 2 responses in flight. Required: `inst_valid`/`inst_fault`/`inst` go to 0 asynchronously, and no stale response appears after release. The first new request responds after exactly `LATENCY` cycles.
- Sweep `LATENCY` 1 and 4 with alternating `inst_ena` 1/0. Required: valid pattern reproduces the request pattern delayed by exactly `LATENCY` cycles.
